// File: rtl/ysyx_040978_ifu_if.sv
// Handshake bundle between the instruction fetch unit, instruction memory and decode.
// The master side is the IFU; the slave side is the memory/decode/execute environment.
interface ysyx_040978_ifu_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_rsp_valid;
    logic [INST_LEN-1:0] imem_rsp_data;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [INST_LEN-1:0] out_inst;
    logic                out_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault
    );
endinterface

// File: rtl/ysyx_040978_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem request in flight, hands instructions to decode.
// Define YSYX_040978_IFU_ALIGN_CHECK_EN to trap misaligned redirect targets instead of masking them.
module ysyx_040978_ifu #(
    parameter int              XLEN     = 64,
    parameter int              INST_LEN = 32,
    parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic                clock,
    input  logic                reset,
    ysyx_040978_ifu_if.master   bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    localparam logic [INST_LEN-1:0] NOP = INST_LEN'(32'h0000_0013);

    state_t              state;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     out_pc_q;
    logic [INST_LEN-1:0] out_inst_q;

    logic            req_fire;
    logic            rsp_live;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_fault;
    logic            fault_hold;
    logic            trapped;
    logic            drop_pending;

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    // A response owed to a request squashed by a fault redirect must not be taken as fresh data.
    assign rsp_live = bus.imem_rsp_valid & ~drop_pending;

    assign bus.imem_req_valid = (state == REQ);
    assign bus.out_valid      = (state == HOLD);
    assign bus.imem_req_addr  = pc;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_inst       = out_inst_q;
    assign bus.out_fault      = fault_hold;

`ifdef YSYX_040978_IFU_ALIGN_CHECK_EN
    logic real_outstanding;

    assign redirect_target  = bus.redirect_pc;
    assign redirect_fault   = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign real_outstanding = req_fire | (state == WAIT) | (state == DROP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_hold   <= 1'b0;
            trapped      <= 1'b0;
            drop_pending <= 1'b0;
        end else if (redirect_fault) begin
            fault_hold   <= 1'b1;
            trapped      <= 1'b0;
            // Responses return in order, so one arriving now retires the oldest owed one.
            drop_pending <= bus.imem_rsp_valid ? (real_outstanding & drop_pending)
                                               : (real_outstanding | drop_pending);
        end else begin
            if (bus.imem_rsp_valid) drop_pending <= 1'b0;
            if (state == HOLD && (bus.out_ready || bus.redirect_valid)) fault_hold <= 1'b0;
            if (bus.redirect_valid) trapped <= 1'b0;
            else if (state == HOLD && fault_hold && bus.out_ready) trapped <= 1'b1;
        end
    end
`else
    assign redirect_target = bus.redirect_pc & ~XLEN'(3);
    assign redirect_fault  = 1'b0;
    assign fault_hold      = 1'b0;
    assign trapped         = 1'b0;
    assign drop_pending    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= PC_RESET;
            out_pc_q   <= '0;
            out_inst_q <= '0;
        end else if (redirect_fault) begin
            state      <= HOLD;
            pc         <= bus.redirect_pc;
            out_pc_q   <= bus.redirect_pc;
            out_inst_q <= NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        pc    <= redirect_target;
                        state <= REQ;
                    end else if (!trapped) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        pc    <= redirect_target;
                        state <= req_fire ? DROP : REQ;
                    end else if (req_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_live) begin
                        if (bus.redirect_valid) begin
                            pc    <= redirect_target;
                            state <= REQ;
                        end else begin
                            out_inst_q <= bus.imem_rsp_data;
                            out_pc_q   <= pc;
                            state      <= HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        pc    <= redirect_target;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.redirect_valid) pc <= redirect_target;
                    if (rsp_live) state <= REQ;
                end
                HOLD: begin
                    // A redirect alongside out_ready still counts as a transfer on the decode side.
                    if (bus.redirect_valid) begin
                        pc    <= redirect_target;
                        state <= REQ;
                    end else if (bus.out_ready) begin
                        if (fault_hold) begin
                            state <= IDLE;
                        end else begin
                            pc    <= pc + XLEN'(4);
                            state <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_040978_ifu.md
# ysyx_040978_ifu

Instruction fetch unit for the single-issue core. It owns the PC and issues one instruction-memory request at a time. It presents each fetched instruction with its PC to the decode stage through a valid/ready handshake; decode resolves opcode and funct fields with the key-select muxes. Redirects from execute (branch/jump) are accepted in every state, and any in-flight response is squashed.

## Interface
- PC_RESET, 64'h0000_0000_8000_0000: PC loaded on reset
- XLEN, 64: PC/address width
- INST_LEN, 32: instruction width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  XLEN  new PC
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (always the PC register)
- imem_rsp_valid  in  1  response data valid (single cycle)
- imem_rsp_data  in  INST_LEN  returned instruction
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  XLEN  PC of presented instruction
- out_inst  out  INST_LEN  presented instruction
- out_fault  out  1  misaligned-fetch marker (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DROP. At most one outstanding request.
- Registers: pc, state, out_pc, out_inst, out_fault.
- imem_req_valid = (state==REQ); out_valid = (state==HOLD); both decoded from state, registered-state only.
- IDLE: go REQ unconditionally.
- REQ: handshake = imem_req_valid & imem_req_ready.
  - Handshake, no redirect -> WAIT.
  - Handshake and redirect -> pc<=redirect_pc, DROP.
  - No handshake, redirect -> pc<=redirect_pc, stay REQ.
- WAIT:
  - rsp_valid, no redirect -> out_inst<=rsp_data, out_pc<=pc, HOLD.
  - rsp_valid and redirect -> discard data, pc<=redirect_pc, REQ.
  - Redirect, no rsp -> pc<=redirect_pc, DROP.
- DROP: discard the next response.
  - rsp_valid -> REQ.
  - Redirect -> pc<=redirect_pc, stay DROP.
- HOLD: outputs stable until transfer.
  - out_ready, no redirect -> pc<=pc+4, REQ.
  - Redirect, with or without out_ready -> pc<=redirect_pc, REQ. If out_ready is also high, that instruction is still transferred.
- PC arithmetic: pc+4 is modulo 2^XLEN, so wrap from all-ones-minus-3 to 0 is legal.
- redirect_pc[1:0] is handled per Configuration.
- imem_rsp_valid in REQ, IDLE or HOLD is a protocol violation and is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=PC_RESET
  - imem_req_valid=0, out_valid=0
  - out_pc=0, out_inst=0, out_fault=0
  - imem_req_addr=PC_RESET
- Reset asserted mid-transaction aborts immediately. A response arriving after reset is released is dropped only if it arrives while in DROP. Memory must be reset together with the IFU.
- First request: imem_req_valid high in the 2nd cycle after reset deassertion.
- Fetch latency:
  - Response accepted in cycle N -> out_valid in N+1.
  - Transfer in cycle M -> next request in M+1.
  - Zero-wait memory throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect takes effect on imem_req_addr in the cycle after redirect_valid is sampled.

## Configuration
- YSYX_040978_IFU_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc unmodified and enters HOLD directly, without issuing a memory request and squashing any outstanding one via DROP semantics.
  - In HOLD it presents out_pc=redirect_pc, out_inst=32'h0000_0013, out_fault=1.
  - Transfer of a fault -> IDLE (core traps; no further fetch until redirect).
  - A redirect while in IDLE after a fault -> pc<=redirect_pc, REQ.
- Not defined: pc<={redirect_pc[XLEN-1:2],2'b00}; out_fault tied 0; the fault path is absent.

## Test plan
- Reset, memory always ready, 1-cycle response 32'h00000513 -> req addr 0x80000000 in cycle 2; out_valid cycle 4 with out_pc=0x80000000; after out_ready, next addr 0x80000004.
- out_ready held low 5 cycles in HOLD -> out_pc/out_inst stable, no new imem request; release -> single transfer, pc+4.
- Redirect to 0x80000100 while in WAIT, response arrives 3 cycles later -> response discarded, out_valid stays 0, next request addr 0x80000100.
- Redirect coincident with imem_rsp_valid in WAIT -> data dropped, request to redirect target on next cycle; redirect coincident with out_ready in HOLD -> one transfer, then fetch at target.
- pc=64'hFFFF_FFFF_FFFF_FFFC, transfer -> next request addr 0.
- With YSYX_040978_IFU_ALIGN_CHECK_EN: redirect to 0x80000102 -> no imem request, out_valid with out_fault=1, out_inst=0x00000013; transfer -> IDLE; redirect 0x80000200 -> request issued. Without the macro: same stimulus fetches 0x80000100 and out_fault=0.
